// File: rtl/axi_wr_slave_mem.sv
// AXI3 write-channel slave with a byte-lane word memory; one burst at a time: 1 AW cycle, L data beats, 1 response cycle.
// Backpressure: awready only in IDLE, wready only in DATA, bvalid/bid/bresp hold until bready.
module axi_wr_slave_mem #(
  parameter int         DEPTH       = 256,
  parameter int         ID_W        = 4,
  parameter logic [1:0] OKAY_RESP   = 2'b00,
  parameter logic [1:0] SLVERR_RESP = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] awid,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [31:0]     awaddr,
  input  logic [1:0]      awburst,
  input  logic            wvalid,
  output logic            wready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  input  logic [31:0]     dbg_addr,
  output logic [31:0]     dbg_rdata
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] id_q;
  logic [3:0]      len_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [31:0]     addr_q;
  logic [31:0]     base_q;
  logic [3:0]      beat_cnt;
  logic            err;

  logic [31:0] mem [DEPTH];

  logic [31:0]      aw_sz_b, aw_span;
  logic             aw_err;
  logic [31:0]      sz_b, wrap_span, incr_addr, wrap_step, wrap_addr, next_addr;
  logic             beat, beat_last, in_range, id_ok, beat_err, mem_we;
  logic [IDX_W-1:0] widx, didx;

  always_comb begin
    aw_sz_b = 32'd1 << awsize;
    aw_span = aw_sz_b * ({28'd0, awlen} + 32'd1);
    aw_err  = (awburst == 2'b11) || (awsize > 3'd2) ||
              (awburst == 2'b10 && !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
              (awburst == 2'b10 && (awaddr & (aw_sz_b - 32'd1)) != 32'd0);
  end

  always_comb begin
    sz_b      = 32'd1 << size_q;
    wrap_span = sz_b * ({28'd0, len_q} + 32'd1);
    incr_addr = (addr_q & ~(sz_b - 32'd1)) + sz_b;
    wrap_step = addr_q + sz_b;
    wrap_addr = (wrap_step == base_q + wrap_span) ? base_q : wrap_step;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b01:   next_addr = incr_addr;
      default: next_addr = wrap_addr;
    endcase
  end

  always_comb begin
    beat      = (state == DATA) && wvalid && wready;
    beat_last = (beat_cnt == len_q);
    in_range  = (addr_q >> 2) < DEPTH_W;
    id_ok     = (wid == id_q);
    // The beat count ends the burst; a disagreeing wlast only poisons the response.
    beat_err  = !in_range || !id_ok || (wlast != beat_last);
    mem_we    = beat && !err && in_range && id_ok;
    widx      = addr_q[IDX_W+1:2];
    didx      = dbg_addr[IDX_W+1:2];
    dbg_rdata = ((dbg_addr >> 2) < DEPTH_W) ? mem[didx] : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= 2'b00;
      id_q     <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      addr_q   <= '0;
      base_q   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid && awready) begin
            id_q     <= awid;
            len_q    <= awlen;
            size_q   <= awsize;
            burst_q  <= awburst;
            addr_q   <= awaddr;
            base_q   <= awaddr & ~(aw_span - 32'd1);
            beat_cnt <= '0;
            err      <= aw_err;
            awready  <= 1'b0;
            wready   <= 1'b1;
            state    <= DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        DATA: begin
          if (beat) begin
            if (beat_err) err <= 1'b1;
            if (beat_last) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err || beat_err) ? SLVERR_RESP : OKAY_RESP;
              state  <= RESP;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              addr_q   <= next_addr;
            end
          end
        end
        RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so an abandoned burst keeps its beats.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Directed bench for axi_wr_slave_mem: burst types, error responses, B backpressure, mid-burst reset.
module tb_axi_wr_slave_mem;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  awid = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [31:0] awaddr = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] dbg_addr = '0;
  logic [31:0] dbg_rdata;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] bd [16];
  logic [3:0]  bs [16];

  axi_wr_slave_mem #(.DEPTH(DEPTH), .ID_W(4)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awaddr(awaddr), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = addr;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done;
    done = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      done = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    if (!done) check("aw_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic send_w(input logic [3:0] id, input int nb, input int lastk);
    bit done;
    for (int k = 0; k < nb; k++) begin
      done = 1'b0;
      wvalid = 1'b1; wid = id; wdata = bd[k]; wstrb = bs[k]; wlast = (k == lastk);
      for (int t = 0; t < 50 && !done; t++) begin
        done = wready;
        @(posedge clk); #1;
      end
      if (!done) check("w_timeout", {31'd0, done}, 32'd1);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic get_b(input string tag, input logic [3:0] eid, input logic [1:0] eresp);
    for (int t = 0; t < 50 && !bvalid; t++) begin
      @(posedge clk); #1;
    end
    check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    check({tag, "_bid"}, {28'd0, bid}, {28'd0, eid});
    check({tag, "_bresp"}, {30'd0, bresp}, {30'd0, eresp});
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check({tag, "_bvalid_fall"}, {31'd0, bvalid}, 32'd0);
    check({tag, "_awready_back"}, {31'd0, awready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      bd[i] = '0;
      bs[i] = 4'hF;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_bid", {28'd0, bid}, 32'd0);
    check("rst_bresp", {30'd0, bresp}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_awready", {31'd0, awready}, 32'd1);

    // INCR 0x10, 4 beats
    for (int i = 0; i < 4; i++) bd[i] = 32'hA0 + i;
    send_aw(4'd3, 32'h10, 4'd3, 3'd2, 2'b01);
    check("incr_wready", {31'd0, wready}, 32'd1);
    send_w(4'd3, 4, 3);
    get_b("incr", 4'd3, 2'b00);
    chk_mem("incr_w4", 32'h10, 32'hA0);
    chk_mem("incr_w5", 32'h14, 32'hA1);
    chk_mem("incr_w6", 32'h18, 32'hA2);
    chk_mem("incr_w7", 32'h1C, 32'hA3);

    // WRAP 0x1C, 4 beats, wraps to 0x10
    bd[0] = 32'hD0D0_0000; bd[1] = 32'hD1D1_1111; bd[2] = 32'hD2D2_2222; bd[3] = 32'hD3D3_3333;
    send_aw(4'd9, 32'h1C, 4'd3, 3'd2, 2'b10);
    send_w(4'd9, 4, 3);
    get_b("wrap", 4'd9, 2'b00);
    chk_mem("wrap_1c", 32'h1C, 32'hD0D0_0000);
    chk_mem("wrap_10", 32'h10, 32'hD1D1_1111);
    chk_mem("wrap_14", 32'h14, 32'hD2D2_2222);
    chk_mem("wrap_18", 32'h18, 32'hD3D3_3333);

    // FIXED 0x40, three single-lane beats into one word (word cleared first)
    bd[0] = 32'h0;
    send_aw(4'd1, 32'h40, 4'd0, 3'd2, 2'b01);
    send_w(4'd1, 1, 0);
    get_b("clr40", 4'd1, 2'b00);
    bd[0] = 32'h0000_0011; bs[0] = 4'b0001;
    bd[1] = 32'h0000_2200; bs[1] = 4'b0010;
    bd[2] = 32'h0033_0000; bs[2] = 4'b0100;
    send_aw(4'd2, 32'h40, 4'd2, 3'd2, 2'b00);
    send_w(4'd2, 3, 2);
    get_b("fixed", 4'd2, 2'b00);
    chk_mem("fixed_w16", 32'h40, 32'h0033_2211);
    for (int i = 0; i < 4; i++) bs[i] = 4'hF;

    // INCR crossing the top of memory: first beat lands, second is out of range
    bd[0] = 32'hB0; bd[1] = 32'hB1;
    send_aw(4'd4, (DEPTH - 1) * 4, 4'd1, 3'd2, 2'b01);
    send_w(4'd4, 2, 1);
    get_b("edge", 4'd4, 2'b10);
    chk_mem("edge_w255", (DEPTH - 1) * 4, 32'hB0);
    chk_mem("edge_oor", DEPTH * 4, 32'h0);

    // Reserved burst type writes nothing
    bd[0] = 32'hDEAD_BEEF;
    send_aw(4'd7, 32'h14, 4'd0, 3'd2, 2'b11);
    send_w(4'd7, 1, 0);
    get_b("rsvd", 4'd7, 2'b10);
    chk_mem("rsvd_nowrite", 32'h14, 32'hD2D2_2222);

    // B backpressure with a pending AW
    bd[0] = 32'h55;
    send_aw(4'd5, 32'h60, 4'd0, 3'd2, 2'b01);
    send_w(4'd5, 1, 0);
    for (int t = 0; t < 50 && !bvalid; t++) begin
      @(posedge clk); #1;
    end
    awid = 4'd6; awaddr = 32'h64; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_bvalid", {31'd0, bvalid}, 32'd1);
      check("hold_bid", {28'd0, bid}, 32'd5);
      check("hold_bresp", {30'd0, bresp}, 32'd0);
      check("hold_awready", {31'd0, awready}, 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("hold_bvalid_fall", {31'd0, bvalid}, 32'd0);
    check("hold_awready_rise", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("hold_aw_taken", {31'd0, awready}, 32'd0);
    check("hold_wready", {31'd0, wready}, 32'd1);
    bd[0] = 32'h66;
    send_w(4'd6, 1, 0);
    get_b("hold2", 4'd6, 2'b00);
    chk_mem("hold_w60", 32'h60, 32'h55);
    chk_mem("hold_w64", 32'h64, 32'h66);

    // Reset after two beats of a 4-beat INCR (target words pre-cleared)
    for (int i = 0; i < 4; i++) bd[i] = 32'h0;
    send_aw(4'd8, 32'h80, 4'd3, 3'd2, 2'b01);
    send_w(4'd8, 4, 3);
    get_b("clr80", 4'd8, 2'b00);
    for (int i = 0; i < 4; i++) bd[i] = 32'hC0 + i;
    send_aw(4'd10, 32'h80, 4'd3, 3'd2, 2'b01);
    send_w(4'd10, 2, 3);
    reset = 1'b1;
    #1;
    check("mrst_awready", {31'd0, awready}, 32'd0);
    check("mrst_wready", {31'd0, wready}, 32'd0);
    check("mrst_bvalid", {31'd0, bvalid}, 32'd0);
    check("mrst_bid", {28'd0, bid}, 32'd0);
    check("mrst_bresp", {30'd0, bresp}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mrst_no_bvalid", {31'd0, bvalid}, 32'd0);
    chk_mem("mrst_w32", 32'h80, 32'hC0);
    chk_mem("mrst_w33", 32'h84, 32'hC1);
    chk_mem("mrst_w34", 32'h88, 32'h0);
    bd[0] = 32'hE0; bd[1] = 32'hE1;
    send_aw(4'd11, 32'h88, 4'd1, 3'd2, 2'b01);
    send_w(4'd11, 2, 1);
    get_b("post", 4'd11, 2'b00);
    chk_mem("post_w34", 32'h88, 32'hE0);
    chk_mem("post_w35", 32'h8C, 32'hE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
AXI3-style write-channel slave that consumes the AW, W and B channels of the team's AXI bus interface. It sits directly downstream of the bus master. It accepts one write burst at a time, computes per-beat addresses for FIXED, INCR and WRAP bursts, and writes the beats byte-lane-wise into an internal word memory. It then returns a single write response per burst. A combinational debug read port gives the bench memory visibility.

Parameters:
DEPTH, 256, number of 32-bit memory words; a byte address is valid iff (addr>>2) < DEPTH
ID_W, 4, width of awid/wid/bid
OKAY_RESP, 2'b00, bresp value on success
SLVERR_RESP, 2'b10, bresp value on any error

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
awvalid  in  1  write address valid
awready  out  1  slave accepts address
awid  in  4  transaction ID
awlen  in  4  beats minus 1 (1..16 beats)
awsize  in  3  bytes per beat = 1<<awsize
awaddr  in  32  start byte address
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
wvalid  in  1  write data valid
wready  out  1  slave accepts data
wid  in  4  data ID
wdata  in  32  write data
wstrb  in  4  byte-lane enables
wlast  in  1  master's last-beat marker
bvalid  out  1  response valid
bready  in  1  master accepts response
bid  out  4  response ID (= captured awid)
bresp  out  2  OKAY or SLVERR
dbg_addr  in  32  debug byte address
dbg_rdata  out  32  combinational memory word at dbg_addr>>2; 0 if out of range

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; awready=0, wready=0, bvalid=0, bid=0, bresp=0.
  - Internal address, beat counter and error flag are cleared.
  - Memory contents are not reset.
  - A reset mid-burst abandons the burst: no B response is issued and beats already written stay written.
- Single outstanding transaction. Registered outputs:
  - awready=1 only in IDLE, from the first edge after reset release.
  - wready=1 only in DATA.
  - bvalid=1 only in RESP.
- IDLE: on awvalid&&awready, capture id, len, size, burst and addr. Clear beat_cnt and err. Go to DATA.
- Address phase sets err if any of the following holds:
  - awburst==11.
  - awsize>2.
  - WRAP with awlen not in {1,3,7,15}.
  - WRAP with awaddr not aligned to size.
- DATA: each wvalid&&wready is one beat at the current address A.
  - The memory write occurs iff !err, the beat is in range and wid matches the captured id.
  - Only byte lanes with wstrb[i]=1 are written; wstrb is honoured as given, including for narrow transfers.
  - An out-of-range beat or wid mismatch sets err; that beat and all later beats of the burst are not written.
  - Beat k is last iff beat_cnt==len. The beat count is authoritative.
  - wlast!=(beat is last) sets err; the burst still ends on the count.
  - On the last beat go to RESP. Otherwise beat_cnt increments and A advances.
- Address advance (S=1<<size, L=len+1):
  - FIXED: A unchanged.
  - INCR: A=(A & ~(S-1))+S, aligning down first. 32-bit wrap-around is allowed; the resulting high address is flagged out of range.
  - WRAP: base=A0 & ~(S*L-1); next=A+S; if next==base+S*L then next=base.
- RESP: bvalid=1, bid=captured id, bresp=err?SLVERR:OKAY. These hold stable until bready.
  - On bvalid&&bready, bvalid falls next cycle and the block returns to IDLE; awready=1 in that same cycle.
- Throughput: minimum 1 + L + 1 cycles per burst with an always-ready master.
- wvalid while in IDLE or RESP is ignored (wready=0). awvalid outside IDLE waits (awready=0).
- Simultaneous awvalid and wvalid in IDLE: only the address is taken that cycle; the data beat is accepted from the next cycle.

Test Plan:
- INCR, awaddr=0x10, awlen=3, awsize=2, wdata=0xA0..0xA3, wstrb=F -> words 4..7 = 0xA0..0xA3; bresp=00, bid=awid.
- WRAP, awaddr=0x1C, awlen=3, awsize=2, data D0..D3 -> D0@0x1C, D1@0x10, D2@0x14, D3@0x18; bresp=00.
- FIXED, awaddr=0x40, awlen=2, wstrb=1,2,4 with bytes 11,22,33 -> word 16 = 0x00332211; bresp=00.
- INCR, awaddr=(DEPTH-1)*4, awlen=1 -> first word written, second beat dropped; bresp=10. Separately, awburst=11 -> nothing written, bresp=10.
- Hold bready=0 for 5 cycles in RESP -> bvalid, bid and bresp stable; awready=0; the next AW is accepted only after the handshake.
- Assert reset after beat 2 of a 4-beat INCR -> all outputs 0, no bvalid, beats 0..1 retained; a new burst completes normally after release.
